// File: rtl/bcd_time_keeper.sv
// bcd_time_keeper: 24-hour HH:MM:SS time-of-day engine in packed BCD.
// Ports: clk, rst (async, active-high), en, load_valid/load_time in;
//   load_ack, load_err, time_bcd, sec_tick, day_wrap,
//   digit_bcd and digit_sel (six-digit display scan) out.
module bcd_time_keeper #(
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int SCAN_DIV      = 50_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        load_valid,
   input  logic [23:0] load_time,
   output logic        load_ack,
   output logic        load_err,
   output logic [23:0] time_bcd,
   output logic        sec_tick,
   output logic        day_wrap,
   output logic [3:0]  digit_bcd,
   output logic [5:0]  digit_sel
);

   localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(TICKS_PER_SEC - 1);
   localparam logic [SW-1:0] S_LAST = SW'(SCAN_DIV - 1);

   logic [PW-1:0] presc;
   logic [SW-1:0] scan_cnt;
   logic [2:0]    idx;
   logic          tick;
   logic          load_ok;
   logic          wrap;
   logic [23:0]   time_inc;
   logic [3:0]    su, st, mu, mt, hu, ht;

   assign su = time_bcd[3:0];
   assign st = time_bcd[7:4];
   assign mu = time_bcd[11:8];
   assign mt = time_bcd[15:12];
   assign hu = time_bcd[19:16];
   assign ht = time_bcd[23:20];

   assign tick = en && (presc == P_LAST);

   // Range check of a requested load time
   always_comb begin
      load_ok = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (load_time[i*4 +: 4] > 4'd9) load_ok = 1'b0;
      end
      if (load_time[7:4] > 4'd5)   load_ok = 1'b0;
      if (load_time[15:12] > 4'd5) load_ok = 1'b0;
      if (load_time[23:20] > 4'd2) load_ok = 1'b0;
      if (load_time[23:20] == 4'd2 && load_time[19:16] > 4'd3)
         load_ok = 1'b0;
   end

   // Next-second value with the BCD carry ripple
   always_comb begin
      time_inc = time_bcd;
      wrap     = 1'b0;
      if (su != 4'd9) begin
         time_inc[3:0] = su + 4'd1;
      end else begin
         time_inc[3:0] = 4'd0;
         if (st != 4'd5) begin
            time_inc[7:4] = st + 4'd1;
         end else begin
            time_inc[7:4] = 4'd0;
            if (mu != 4'd9) begin
               time_inc[11:8] = mu + 4'd1;
            end else begin
               time_inc[11:8] = 4'd0;
               if (mt != 4'd5) begin
                  time_inc[15:12] = mt + 4'd1;
               end else begin
                  time_inc[15:12] = 4'd0;
                  if (ht == 4'd2 && hu == 4'd3) begin
                     time_inc[23:16] = 8'h00;
                     wrap = 1'b1;
                  end else if (hu == 4'd9) begin
                     time_inc[19:16] = 4'd0;
                     time_inc[23:20] = ht + 4'd1;
                  end else begin
                     time_inc[19:16] = hu + 4'd1;
                  end
               end
            end
         end
      end
   end

   // Time and prescaler. A load request (good or bad) takes the
   // cycle: a rejected load leaves prescaler and time untouched.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc    <= '0;
         time_bcd <= 24'h000000;
         load_ack <= 1'b0;
         load_err <= 1'b0;
         sec_tick <= 1'b0;
         day_wrap <= 1'b0;
      end else begin
         load_ack <= 1'b0;
         load_err <= 1'b0;
         sec_tick <= 1'b0;
         day_wrap <= 1'b0;
         if (load_valid) begin
            if (load_ok) begin
               time_bcd <= load_time;
               presc    <= '0;
               load_ack <= 1'b1;
            end else begin
               load_err <= 1'b1;
            end
         end else if (tick) begin
            presc    <= '0;
            time_bcd <= time_inc;
            sec_tick <= 1'b1;
            day_wrap <= wrap;
         end else if (en) begin
            presc <= presc + 1'b1;
         end
      end
   end

   // Display scan, free-running
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt  <= '0;
         idx       <= 3'd0;
         digit_sel <= 6'b000001;
      end else if (scan_cnt == S_LAST) begin
         scan_cnt  <= '0;
         idx       <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
         digit_sel <= {digit_sel[4:0], digit_sel[5]};
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   always_comb begin
      digit_bcd = 4'd0;
      unique case (idx)
         3'd0:    digit_bcd = su;
         3'd1:    digit_bcd = st;
         3'd2:    digit_bcd = mu;
         3'd3:    digit_bcd = mt;
         3'd4:    digit_bcd = hu;
         3'd5:    digit_bcd = ht;
         default: digit_bcd = 4'd0;
      endcase
   end

endmodule
